// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the MAC address filter.
//   ETH_MAC_W / ETH_TYPE_W : header field widths
//   ETH_BCAST_MAC          : all-ones broadcast destination
//   filt_state_e           : filter FSM encoding
//   mac_accept()           : destination accept rule
package eth_pkg;

    localparam int ETH_MAC_W  = 48;
    localparam int ETH_TYPE_W = 16;

    localparam logic [ETH_MAC_W-1:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        FILT_IDLE    = 2'd0,
        FILT_FORWARD = 2'd1,
        FILT_DROP    = 2'd2
    } filt_state_e;

    // dest[40] is the I/G bit of the first octet on the wire.
    // Broadcast also has it set, so it is excluded from the multicast
    // term and is only accepted through its own enable.
    function automatic logic mac_accept(
        input logic [ETH_MAC_W-1:0] dest,
        input logic [ETH_MAC_W-1:0] local_mac,
        input logic                 promisc,
        input logic                 bcast_en,
        input logic                 mcast_en
    );
        logic is_bcast;
        is_bcast = (dest == ETH_BCAST_MAC);
        return promisc
            || (dest == local_mac)
            || (bcast_en && is_bcast)
            || (mcast_en && dest[40] && !is_bcast);
    endfunction

endpackage

// File: rtl/eth_axis_skid.sv
// Two-entry registered AXI-stream buffer.
//   s_* : upstream beat (tdata/tkeep/tlast/tuser, valid/ready)
//   m_* : downstream beat, one cycle of latency
//   busy: either entry holds a beat
// s_tready comes straight from a flop, so there is no combinational
// path from m_tready back upstream. The second entry absorbs the beat
// that arrives in the cycle the output stalls.
module eth_axis_skid #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  busy
);

    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 2;

    logic [BW-1:0] in_beat, out_beat, skid_beat;
    logic          out_valid, skid_valid;
    logic          in_fire, out_free;

    assign in_beat  = {s_tdata, s_tkeep, s_tlast, s_tuser};
    assign s_tready = !skid_valid;
    assign in_fire  = s_tvalid && !skid_valid;
    assign out_free = !out_valid || m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // Skid entry drains first to keep beat order.
            if (skid_valid) begin
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (out_free) begin
            if (skid_valid)   out_beat <= skid_beat;
            else if (in_fire) out_beat <= in_beat;
        end else if (in_fire) begin
            skid_beat <= in_beat;
        end
    end

    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = out_beat;
    assign m_tvalid = out_valid;
    assign busy     = out_valid || skid_valid;

endmodule

// File: rtl/eth_mac_filter.sv
// Destination-MAC filter between an Ethernet frame receiver and the
// rest of the receive path.
//   s_eth_hdr_* / s_eth_payload_axis_* : incoming header + payload
//   m_eth_hdr_* / m_eth_payload_axis_* : frames that pass the filter
//   local_mac, cfg_*                   : accept controls, sampled at header
//   stat_frame_pass/drop               : one-cycle pulse per decision
//   busy                               : frame in progress or buffer draining
// Accepted payload goes through a two-entry skid buffer; rejected
// payload is swallowed at full rate.
module eth_mac_filter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
    input  logic [ETH_MAC_W-1:0]  s_eth_src_mac,
    input  logic [ETH_TYPE_W-1:0] s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [ETH_MAC_W-1:0]  m_eth_dest_mac,
    output logic [ETH_MAC_W-1:0]  m_eth_src_mac,
    output logic [ETH_TYPE_W-1:0] m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,

    input  logic [ETH_MAC_W-1:0]  local_mac,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,

    output logic                  stat_frame_pass,
    output logic                  stat_frame_drop,
    output logic                  busy
);

    filt_state_e state, state_nxt;

    logic hdr_fire, accept, pay_fire;
    logic skid_in_valid, skid_s_ready, skid_busy;
    logic [KEEP_WIDTH-1:0] in_keep;

    assign accept   = mac_accept(s_eth_dest_mac, local_mac,
                                 cfg_promisc, cfg_bcast_en, cfg_mcast_en);
    assign hdr_fire = s_eth_hdr_valid && s_eth_hdr_ready;
    assign pay_fire = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign in_keep  = KEEP_ENABLE ? s_eth_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt                 = state;
        s_eth_hdr_ready           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        skid_in_valid             = 1'b0;
        case (state)
            FILT_IDLE: begin
                // rst_n term keeps the header port closed while reset is held.
                s_eth_hdr_ready = rst_n && (!m_eth_hdr_valid || m_eth_hdr_ready);
                if (hdr_fire) state_nxt = accept ? FILT_FORWARD : FILT_DROP;
            end
            FILT_FORWARD: begin
                s_eth_payload_axis_tready = skid_s_ready;
                skid_in_valid             = s_eth_payload_axis_tvalid;
                if (pay_fire && s_eth_payload_axis_tlast) state_nxt = FILT_IDLE;
            end
            FILT_DROP: begin
                s_eth_payload_axis_tready = 1'b1;
                if (pay_fire && s_eth_payload_axis_tlast) state_nxt = FILT_IDLE;
            end
            default: state_nxt = FILT_IDLE;
        endcase
    end

    // Header output register: a new header can only load when the slot
    // is empty or being taken this cycle (enforced by s_eth_hdr_ready).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_eth_hdr_valid <= 1'b0;
            stat_frame_pass <= 1'b0;
            stat_frame_drop <= 1'b0;
        end else begin
            stat_frame_pass <= hdr_fire && accept;
            stat_frame_drop <= hdr_fire && !accept;
            if (hdr_fire && accept)   m_eth_hdr_valid <= 1'b1;
            else if (m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_fire && accept) begin
            m_eth_dest_mac <= s_eth_dest_mac;
            m_eth_src_mac  <= s_eth_src_mac;
            m_eth_type     <= s_eth_type;
        end
    end

    eth_axis_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_eth_payload_axis_tdata),
        .s_tkeep  (in_keep),
        .s_tvalid (skid_in_valid),
        .s_tready (skid_s_ready),
        .s_tlast  (s_eth_payload_axis_tlast),
        .s_tuser  (s_eth_payload_axis_tuser),
        .m_tdata  (m_eth_payload_axis_tdata),
        .m_tkeep  (m_eth_payload_axis_tkeep),
        .m_tvalid (m_eth_payload_axis_tvalid),
        .m_tready (m_eth_payload_axis_tready),
        .m_tlast  (m_eth_payload_axis_tlast),
        .m_tuser  (m_eth_payload_axis_tuser),
        .busy     (skid_busy)
    );

    assign busy = (state != FILT_IDLE) || skid_busy;

endmodule

// File: tb/tb_eth_mac_filter.sv
module tb_eth_mac_filter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_hdr_valid = 1'b0, s_hdr_ready;
    logic [47:0]   s_dest = '0, s_src = '0;
    logic [15:0]   s_type = '0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
    logic          m_hdr_valid, m_hdr_ready = 1'b0;
    logic [47:0]   m_dest, m_src;
    logic [15:0]   m_type;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid, m_tready = 1'b0, m_tlast, m_tuser;
    logic [47:0]   local_mac = LMAC;
    logic          cfg_promisc = 1'b0, cfg_bcast_en = 1'b0, cfg_mcast_en = 1'b0;
    logic          stat_pass, stat_drop, busy;

    always #5 clk = ~clk;

    eth_mac_filter #(.DATA_WIDTH(DW), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
        .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
        .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
        .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
        .local_mac(local_mac), .cfg_promisc(cfg_promisc),
        .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
        .stat_frame_pass(stat_pass), .stat_frame_drop(stat_drop), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    int n_tests = 0, n_fail = 0;
    logic [111:0] hdr_q[$];
    beat_t        beat_q[$];
    int pass_seen = 0, drop_seen = 0, hdr_seen = 0, bytes_seen = 0;
    int pass_exp = 0, drop_exp = 0;

    // Output ready generators
    bit tr_mode = 1'b0;   // 1: random 50%
    bit tr_force = 1'b1;  // level when not random
    bit hr_mode = 1'b0;
    int hdr_hold = 0;     // cycles to hold m_hdr_ready low

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Accept rule straight from the filter definition.
    function automatic bit model_accept(input logic [47:0] d, input logic [47:0] l,
                                        input bit p, input bit b, input bit m);
        if (p) return 1'b1;
        if (d == l) return 1'b1;
        if (d == BCAST) return b;
        if (d[40]) return m;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = tr_mode ? 1'($urandom_range(1)) : tr_force;
        if (hdr_hold > 0) begin
            m_hdr_ready = 1'b0;
            hdr_hold--;
        end else begin
            m_hdr_ready = hr_mode ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Scoreboard: a transfer completes at the next posedge when valid&ready here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_hdr_valid && m_hdr_ready) begin
                hdr_seen++;
                if (hdr_q.size() == 0) fail_now("hdr_unexpected");
                else chk("hdr_fields", {16'h0, m_dest, m_src, m_type}, {16'h0, hdr_q.pop_front()});
            end
            if (m_tvalid && m_tready) begin
                bytes_seen += $countones(m_tkeep);
                if (beat_q.size() == 0) fail_now("beat_unexpected");
                else chk("beat", {54'h0, m_tdata, m_tkeep, m_tlast, m_tuser},
                         {54'h0, beat_q.pop_front()});
            end
            if (stat_pass) pass_seen++;
            if (stat_drop) drop_seen++;
        end
    end

    task automatic send_frame(input logic [47:0] dest, input int nbytes, input bit chaos);
        bit ok, acc;
        int nb;
        beat_t bt;
        acc = 1'b0;
        @(posedge clk);
        #1;
        s_hdr_valid = 1'b1;
        s_dest = dest;
        s_src  = {$urandom, 16'($urandom)};
        s_type = 16'($urandom);
        ok = 1'b0;
        for (int g = 0; g < 3000 && !ok; g++) begin
            @(negedge clk);
            if (s_hdr_ready) begin
                ok  = 1'b1;
                acc = model_accept(dest, local_mac, cfg_promisc, cfg_bcast_en, cfg_mcast_en);
            end
            @(posedge clk);
            #1;
        end
        s_hdr_valid = 1'b0;
        if (!ok) begin
            fail_now("hdr_accept_timeout");
            return;
        end
        if (acc) begin
            hdr_q.push_back({dest, s_src, s_type});
            pass_exp++;
        end else begin
            drop_exp++;
        end
        if (chaos) begin
            // Settings changed mid-frame must not affect this frame.
            local_mac    = {$urandom, 16'($urandom)};
            cfg_promisc  = 1'($urandom_range(1));
            cfg_bcast_en = 1'($urandom_range(1));
            cfg_mcast_en = 1'($urandom_range(1));
        end
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (chaos && $urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            bt.d = {$urandom, $urandom};
            bt.l = (b == nb - 1);
            bt.k = bt.l ? KW'((1 << (nbytes - 8 * b)) - 1) : '1;
            bt.u = bt.l ? 1'($urandom_range(1)) : 1'b0;
            {s_tdata, s_tkeep, s_tlast, s_tuser} = bt;
            s_tvalid = 1'b1;
            ok = 1'b0;
            for (int g = 0; g < 3000 && !ok; g++) begin
                @(negedge clk);
                if (s_tready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b0;
            if (!ok) begin
                fail_now("beat_accept_timeout");
                return;
            end
            if (acc) beat_q.push_back(bt);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int g = 0; g < 5000 && !done; g++) begin
            @(negedge clk);
            if (!busy && !m_hdr_valid && hdr_q.size() == 0 && beat_q.size() == 0) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [47:0] dest;
        bit          p, b, m;
        int          nbytes;
        bit          exp_pass;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int p0, d0, h0, b0, sel;
        logic [47:0] dst;

        vecs[0]  = '{LMAC,                 0, 0, 0, 60, 1};
        vecs[1]  = '{48'h02_00_00_00_00_02, 0, 0, 0, 60, 0};
        vecs[2]  = '{LMAC,                 0, 0, 0, 60, 1};
        vecs[3]  = '{BCAST,                0, 0, 0, 17, 0};
        vecs[4]  = '{BCAST,                0, 1, 0, 17, 1};
        vecs[5]  = '{48'h01_00_5E_00_00_01, 0, 0, 1,  1, 1};
        vecs[6]  = '{48'h01_00_5E_00_00_01, 0, 0, 0,  8, 0};
        vecs[7]  = '{BCAST,                0, 0, 1,  9, 0};
        vecs[8]  = '{48'h0A_0B_0C_0D_0E_0F, 1, 0, 0,  1, 1};
        vecs[9]  = '{48'h02_00_00_00_00_02, 0, 0, 0,  1, 0};
        vecs[10] = '{48'h01_00_5E_7F_00_09, 0, 1, 1, 24, 1};

        // Reset state while reset is held
        #13;
        chk("rst_m_hdr_valid", 128'(m_hdr_valid), 128'd0);
        chk("rst_m_tvalid",    128'(m_tvalid),    128'd0);
        chk("rst_s_hdr_ready", 128'(s_hdr_ready), 128'd0);
        chk("rst_s_tready",    128'(s_tready),    128'd0);
        chk("rst_busy",        128'(busy),        128'd0);
        chk("rst_stats",       128'({stat_pass, stat_drop}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_hdr_ready", 128'(s_hdr_ready), 128'd1);

        // Directed frames
        for (int i = 0; i < 11; i++) begin
            cfg_promisc = vecs[i].p; cfg_bcast_en = vecs[i].b; cfg_mcast_en = vecs[i].m;
            p0 = pass_seen; d0 = drop_seen; h0 = hdr_seen; b0 = bytes_seen;
            send_frame(vecs[i].dest, vecs[i].nbytes, 1'b0);
            wait_drain();
            chk($sformatf("v%0d_pass", i),  128'(pass_seen - p0),  128'(vecs[i].exp_pass));
            chk($sformatf("v%0d_drop", i),  128'(drop_seen - d0),  128'(!vecs[i].exp_pass));
            chk($sformatf("v%0d_hdrs", i),  128'(hdr_seen - h0),   128'(vecs[i].exp_pass));
            chk($sformatf("v%0d_bytes", i), 128'(bytes_seen - b0),
                vecs[i].exp_pass ? 128'(vecs[i].nbytes) : 128'd0);
        end

        // Reset mid-FORWARD with the output stalled
        cfg_promisc = 0; cfg_bcast_en = 0; cfg_mcast_en = 0;
        tr_force = 1'b0;
        hdr_hold = 1000;
        @(posedge clk); #1;
        s_hdr_valid = 1'b1; s_dest = LMAC; s_src = 48'h1; s_type = 16'h0800;
        @(negedge clk);
        chk("rt_hdr_ready", 128'(s_hdr_ready), 128'd1);
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
        s_tvalid = 1'b1; s_tdata = 64'h1122334455667788; s_tkeep = '1; s_tlast = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rt_m_hdr_valid", 128'(m_hdr_valid), 128'd0);
        chk("rt_m_tvalid",    128'(m_tvalid),    128'd0);
        chk("rt_s_tready",    128'(s_tready),    128'd0);
        chk("rt_busy",        128'(busy),        128'd0);
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hdr_hold = 0;
        tr_force = 1'b1;
        hdr_q.delete();
        beat_q.delete();
        #1;
        chk("rt_hdr_ready_after", 128'(s_hdr_ready), 128'd1);
        p0 = pass_seen; h0 = hdr_seen; b0 = bytes_seen;
        send_frame(LMAC, 30, 1'b0);
        wait_drain();
        chk("rt_pass",  128'(pass_seen - p0),  128'd1);
        chk("rt_hdrs",  128'(hdr_seen - h0),   128'd1);
        chk("rt_bytes", 128'(bytes_seen - b0), 128'd30);

        // Randomized back-to-back frames under backpressure
        pass_exp = 0; drop_exp = 0;
        p0 = pass_seen; d0 = drop_seen;
        tr_mode = 1'b1; hr_mode = 1'b1;
        hdr_hold = 20;
        for (int f = 0; f < 100; f++) begin
            local_mac    = ($urandom_range(1) == 0) ? LMAC : {$urandom, 16'($urandom)};
            cfg_promisc  = ($urandom_range(9) == 0);
            cfg_bcast_en = 1'($urandom_range(1));
            cfg_mcast_en = 1'($urandom_range(1));
            sel = $urandom_range(4);
            case (sel)
                0: dst = local_mac;
                1: dst = BCAST;
                2: dst = {$urandom, 16'($urandom)} | 48'h01_00_00_00_00_00;
                3: dst = {$urandom, 16'($urandom)} & 48'hFE_FF_FF_FF_FF_FF;
                default: dst = {$urandom, 16'($urandom)};
            endcase
            send_frame(dst, ($urandom_range(99) < 15) ? 1 : $urandom_range(100, 1), 1'b1);
        end
        wait_drain();
        chk("rand_pass_count", 128'(pass_seen - p0), 128'(pass_exp));
        chk("rand_drop_count", 128'(drop_seen - d0), 128'(drop_exp));
        chk("rand_q_empty", 128'(hdr_q.size() + beat_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
